// File: rtl/cpu_result_collector.sv
// cpu_result_collector: captures cpu result handshakes into a record FIFO.
// Define CRC_STATS_EN to add saturating carry/borrow record counters.
module cpu_result_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [CNT_W-1:0]         rec_limit,
  input  logic                     result_ready,
  input  logic [7:0]               opcode,
  input  logic [7:0]               operand_A_out,
  input  logic [7:0]               operand_B_out,
  input  logic [7:0]               result_out_cpu,
  input  logic                     carry_out_cpu,
  input  logic                     borrow_out_cpu,
  input  logic [7:0]               pc_out,
  output logic                     next_out,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [41:0]              rec_data,
  output logic [CNT_W-1:0]         rec_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done
`ifdef CRC_STATS_EN
  ,
  output logic [15:0]              carry_cnt,
  output logic [15:0]              borrow_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  logic [41:0]      mem_data [DEPTH];
  logic [CNT_W-1:0] mem_seq  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] seq;
  logic [CNT_W-1:0] captured;
  logic [CW-1:0]    count_nxt;
  logic [41:0]      wr_data;
  logic             push;
  logic             pop;
  logic             last;
  logic             arm_ok;

  assign rec_valid = (count != '0);
  assign push      = (state == S_RUN) && next_out && result_ready;
  assign pop       = rec_valid && rec_ready;
  assign arm_ok    = arm && (state != S_RUN);
  assign last      = (rec_limit != '0) &&
                     (captured == rec_limit - CNT_W'(1));

  assign wr_data = {pc_out, opcode, operand_A_out,
                    operand_B_out, result_out_cpu,
                    carry_out_cpu, borrow_out_cpu};

  // Head is forced to zero when empty so stale slots never leak out.
  assign rec_data = rec_valid ? mem_data[rd_ptr] : '0;
  assign rec_seq  = rec_valid ? mem_seq[rd_ptr]  : '0;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= wr_data;
      mem_seq[wr_ptr]  <= seq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      next_out <= 1'b0;
      done     <= 1'b0;
      seq      <= '0;
      captured <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (state)
        S_RUN: begin
          if (push) begin
            seq      <= seq + CNT_W'(1);
            captured <= captured + CNT_W'(1);
          end
          if (push && last) begin
            state    <= S_DONE;
            done     <= 1'b1;
            next_out <= 1'b0;
          end else begin
            next_out <= (count_nxt < FULL);
          end
        end
        S_IDLE, S_DONE: begin
          next_out <= 1'b0;
          if (arm_ok) begin
            state    <= S_RUN;
            done     <= 1'b0;
            seq      <= '0;
            captured <= '0;
            next_out <= (count_nxt < FULL);
          end
        end
        default: begin
          state    <= S_IDLE;
          next_out <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

`ifdef CRC_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_cnt  <= '0;
      borrow_cnt <= '0;
    end else if (arm_ok) begin
      carry_cnt  <= '0;
      borrow_cnt <= '0;
    end else if (push) begin
      if (carry_out_cpu && carry_cnt != 16'hFFFF)
        carry_cnt <= carry_cnt + 16'd1;
      if (borrow_out_cpu && borrow_cnt != 16'hFFFF)
        borrow_cnt <= borrow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_result_collector.sv
// Directed bench for cpu_result_collector: vector table plus
// hand-written full-FIFO, backpressure and reset sequences.
module tb_cpu_result_collector;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       cy;
    logic       bw;
  } rec_t;

  typedef struct {
    rec_t        r;
    logic [41:0] exp_data;
    logic [7:0]  exp_seq;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             arm;
  logic [CNT_W-1:0] rec_limit;
  logic             result_ready;
  logic [7:0]       opcode;
  logic [7:0]       operand_A_out;
  logic [7:0]       operand_B_out;
  logic [7:0]       result_out_cpu;
  logic             carry_out_cpu;
  logic             borrow_out_cpu;
  logic [7:0]       pc_out;
  logic             next_out;
  logic             rec_valid;
  logic             rec_ready;
  logic [41:0]      rec_data;
  logic [CNT_W-1:0] rec_seq;
  logic [3:0]       count;
  logic             done;
`ifdef CRC_STATS_EN
  logic [15:0]      carry_cnt;
  logic [15:0]      borrow_cnt;
`endif

  cpu_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .arm            (arm),
    .rec_limit      (rec_limit),
    .result_ready   (result_ready),
    .opcode         (opcode),
    .operand_A_out  (operand_A_out),
    .operand_B_out  (operand_B_out),
    .result_out_cpu (result_out_cpu),
    .carry_out_cpu  (carry_out_cpu),
    .borrow_out_cpu (borrow_out_cpu),
    .pc_out         (pc_out),
    .next_out       (next_out),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .rec_data       (rec_data),
    .rec_seq        (rec_seq),
    .count          (count),
    .done           (done)
`ifdef CRC_STATS_EN
    ,
    .carry_cnt      (carry_cnt),
    .borrow_cnt     (borrow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_miss;
  int          exp_seq;
  int          gen;
  rec_t        cur;
  logic [41:0] q_data [$];
  logic [7:0]  q_seq  [$];
  vec_t        tbl [3];

  function automatic rec_t mk(int i);
    rec_t r;
    r.pc  = 8'(i);
    r.op  = 8'(i * 5 + 1);
    r.a   = 8'(200 - i);
    r.b   = 8'(i * 3);
    r.res = 8'(i ^ 60);
    r.cy  = i[0];
    r.bw  = i[1];
    return r;
  endfunction

  function automatic logic [41:0] pack(rec_t r);
    return {r.pc, r.op, r.a, r.b, r.res, r.cy, r.bw};
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(rec_t r);
    pc_out         = r.pc;
    opcode         = r.op;
    operand_A_out  = r.a;
    operand_B_out  = r.b;
    result_out_cpu = r.res;
    carry_out_cpu  = r.cy;
    borrow_out_cpu = r.bw;
  endtask

  // One clock of the scoreboard: predict push/pop from the handshake
  // signals visible now, check any popped head, then advance.
  task automatic cycle();
    logic wp;
    logic rp;
    wp = next_out && result_ready;
    rp = rec_valid && rec_ready;
    if (rp) begin
      if (q_data.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL pop_underflow: got a record, want none");
      end else begin
        chk("fifo_data", rec_data, q_data.pop_front());
        chk("fifo_seq", rec_seq, q_seq.pop_front());
      end
    end
    tick();
    if (wp) begin
      q_data.push_back(pack(cur));
      q_seq.push_back(8'(exp_seq));
      exp_seq++;
      gen++;
      cur = mk(gen);
      drive(cur);
    end
  endtask

  task automatic wait_next(string name);
    int k;
    k = 0;
    while (!next_out && k < 20) begin
      tick();
      k++;
    end
    if (!next_out) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: next_out timeout, got 0 want 1", name);
    end
  endtask

  task automatic send(rec_t r);
    drive(r);
    result_ready = 1'b1;
    wait_next("send");
    tick();
    result_ready = 1'b0;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_next_out"}, next_out, 0);
    chk({tag, "_rec_valid"}, rec_valid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rec_data"}, rec_data, 0);
    chk({tag, "_rec_seq"}, rec_seq, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int i = 0; i < 3; i++) begin
      tbl[i].r = '{8'(i), 8'h02, 8'hFB, 8'h03, 8'hFE, 1'b0, 1'b0};
      tbl[i].exp_seq = 8'(i);
    end
    tbl[0].exp_data = 42'h00BEC0FF8;
    tbl[1].exp_data = 42'h40BEC0FF8;
    tbl[2].exp_data = 42'h80BEC0FF8;

    rst          = 1'b1;
    arm          = 1'b0;
    rec_limit    = '0;
    result_ready = 1'b0;
    rec_ready    = 1'b0;
    exp_seq      = 0;
    gen          = 0;
    cur          = mk(0);
    drive(cur);

    #2 rst = 1'b0;
    #1;
    chk_reset("por");
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_next_out", next_out, 0);
    end

    rec_limit = 8'd3;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_next_out", next_out, 1);
    chk("arm_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].r);
      chk("lim_count", count, 4'(i + 1));
      chk("lim_valid", rec_valid, 1);
    end
    chk("lim_done", done, 1);
    chk("lim_next_out", next_out, 0);
    result_ready = 1'b1;
    repeat (3) tick();
    chk("lim_no_extra", count, 3);
    result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tbl_valid", rec_valid, 1);
      chk("tbl_seq", rec_seq, tbl[i].exp_seq);
      chk("tbl_data", rec_data, tbl[i].exp_data);
      if (i == 0) chk("opA_raw", rec_data[25:18], 8'hFB);
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
    end
    chk("drained_valid", rec_valid, 0);
    chk("drained_data", rec_data, 0);

    rec_limit = 8'd0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    exp_seq = 0;
    gen = 0;
    cur = mk(0);
    drive(cur);
    result_ready = 1'b1;
    repeat (8) cycle();
    chk("full_count", count, 8);
    chk("full_next_out", next_out, 0);
    chk("full_done", done, 0);
    repeat (3) cycle();
    chk("held_count", count, 8);
    rec_ready = 1'b1;
    cycle();
    rec_ready = 1'b0;
    chk("pop1_count", count, 7);
    chk("pop1_next_out", next_out, 1);
    cycle();
    chk("ninth_count", count, 8);

    rec_ready = 1'b1;
    cycle();
    chk("stream_first", count, 7);
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("stream_count", count, 7);
    end
    result_ready = 1'b0;
    for (int k = 0; k < 20 && rec_valid; k++) cycle();
    rec_ready = 1'b0;
    chk("stream_empty", count, 0);
    n_vec++;
    if (q_data.size() != 0) begin
      n_miss++;
      $display("FAIL stream_lost: got %0d left, want 0",
               q_data.size());
    end

    rec_limit = 8'd1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    result_ready = 1'b1;
    cycle();
    result_ready = 1'b0;
    chk("armrun_done", done, 0);
    chk("armrun_count", count, 1);
    rec_ready = 1'b1;
    cycle();
    rec_ready = 1'b0;

    #2 rst = 1'b0;
    #1;
    chk_reset("rst1");
    q_data.delete();
    q_seq.delete();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_idle_next", next_out, 0);
    end

    rec_limit = 8'd5;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    exp_seq = 0;
    gen = 100;
    cur = mk(100);
    drive(cur);
    result_ready = 1'b1;
    repeat (2) cycle();
    result_ready = 1'b0;
    chk("mid_count", count, 2);
    #2 rst = 1'b0;
    #1;
    chk_reset("rst2");
    q_data.delete();
    q_seq.delete();
    tick();
    rst = 1'b1;

    rec_limit = 8'd2;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    exp_seq = 0;
    result_ready = 1'b1;
    repeat (2) cycle();
    result_ready = 1'b0;
    chk("rearm_done", done, 1);
    chk("rearm_next_out", next_out, 0);
    rec_ready = 1'b1;
    repeat (2) cycle();
    rec_ready = 1'b0;
    chk("rearm_empty", count, 0);

`ifdef CRC_STATS_EN
    begin
      bit   cys [4];
      bit   bws [4];
      rec_t r;
      cys = '{1'b1, 1'b1, 1'b0, 1'b1};
      bws = '{1'b0, 1'b1, 1'b0, 1'b0};
      rec_limit = 8'd4;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("stat_clr_c", carry_cnt, 0);
      chk("stat_clr_b", borrow_cnt, 0);
      for (int i = 0; i < 4; i++) begin
        r = mk(50 + i);
        r.cy = cys[i];
        r.bw = bws[i];
        send(r);
      end
      chk("stat_carry", carry_cnt, 3);
      chk("stat_borrow", borrow_cnt, 1);
      chk("stat_done", done, 1);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("stat_arm_c", carry_cnt, 0);
      chk("stat_arm_b", borrow_cnt, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
